// File: rtl/dlfloat_host_link.sv
// Host-side link to the DLFloat16 MAC tile: serialises (A, B) operand pairs onto the 16-bit
// tile bus and reassembles the tile's MSB/LSB byte stream into 16-bit results.
// Optional: define DLFLOAT_HOST_LINK_NAN_FLAG_EN to build the sticky nan_seen flag.
module dlfloat_host_link #(
    parameter int RX_SKIP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic [15:0]      tx_data,
    output logic             tx_phase,
    input  logic [7:0]       rx_byte,
    output logic             res_valid,
    output logic [15:0]      res_data,
    output logic [CNT_W-1:0] pair_cnt,
    output logic [CNT_W-1:0] res_cnt,
    output logic             nan_seen
);

    localparam int SKIP_W = (RX_SKIP > 0) ? $clog2(RX_SKIP + 1) : 1;

    logic              slot_full;
    logic [15:0]       slot_a;
    logic [15:0]       slot_b;
    logic [15:0]       b_shadow;
    logic              accept;
    logic              release_slot;

    logic [SKIP_W-1:0] skip_cnt;
    logic              rx_lsb;
    logic [7:0]        msb_q;
    logic              rx_active;

    assign op_ready     = ~slot_full;
    assign accept       = op_valid & ~slot_full;
    // The slot drains on the edge that enters phase 0, so a pair is never split.
    assign release_slot = tx_phase & slot_full;
    assign rx_active    = (skip_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_phase  <= 1'b0;
            tx_data   <= '0;
            b_shadow  <= '0;
            slot_full <= 1'b0;
            slot_a    <= '0;
            slot_b    <= '0;
            pair_cnt  <= '0;
        end else begin
            tx_phase <= ~tx_phase;
            if (tx_phase) begin
                if (slot_full) begin
                    tx_data  <= slot_a;
                    b_shadow <= slot_b;
                    pair_cnt <= pair_cnt + CNT_W'(1);
                end else begin
                    tx_data  <= '0;
                    b_shadow <= '0;
                end
            end else begin
                tx_data <= b_shadow;
            end

            if (accept) begin
                slot_a    <= op_a;
                slot_b    <= op_b;
                slot_full <= 1'b1;
            end else if (release_slot) begin
                slot_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt  <= SKIP_W'(RX_SKIP);
            rx_lsb    <= 1'b0;
            msb_q     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cnt   <= '0;
        end else begin
            res_valid <= 1'b0;
            if (!rx_active) begin
                skip_cnt <= skip_cnt - SKIP_W'(1);
            end else if (!rx_lsb) begin
                msb_q  <= rx_byte;
                rx_lsb <= 1'b1;
            end else begin
                res_data  <= {msb_q, rx_byte};
                res_valid <= 1'b1;
                res_cnt   <= res_cnt + CNT_W'(1);
                rx_lsb    <= 1'b0;
            end
        end
    end

`ifdef DLFLOAT_HOST_LINK_NAN_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_seen <= 1'b0;
        end else if (rx_active && rx_lsb && ({msb_q, rx_byte} == 16'hFFFF)) begin
            nan_seen <= 1'b1;
        end
    end
`else
    assign nan_seen = 1'b0;
`endif

endmodule

// File: tb/tb_dlfloat_host_link.sv
// Scoreboard bench for dlfloat_host_link: randomized operand pairs and rx bytes are
// modelled as queues of expected bus words / results and checked by a separate monitor.
module tb_dlfloat_host_link;

    localparam int RX_SKIP = 1;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [15:0]      op_a = '0;
    logic [15:0]      op_b = '0;
    logic [15:0]      tx_data;
    logic             tx_phase;
    logic [7:0]       rx_byte = '0;
    logic             res_valid;
    logic [15:0]      res_data;
    logic [CNT_W-1:0] pair_cnt;
    logic [CNT_W-1:0] res_cnt;
    logic             nan_seen;

    dlfloat_host_link #(.RX_SKIP(RX_SKIP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .tx_data(tx_data), .tx_phase(tx_phase),
        .rx_byte(rx_byte), .res_valid(res_valid), .res_data(res_data),
        .pair_cnt(pair_cnt), .res_cnt(res_cnt), .nan_seen(nan_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          acc;
    } pair_t;

    pair_t       txq[$];
    pair_t       dir_pairs[$];
    logic [15:0] rxq[$];
    logic [7:0]  dir_bytes[$];
    int          a_log[$];

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   mode = 0;
    int   rx_idx = 0;
    int   rx_pushed = 0;
    logic [7:0] rx_msb = '0;
    logic last_acc = 1'b0;

    int   pairs_seen = 0;
    int   res_seen = 0;
    logic ph_valid = 1'b0;
    logic last_ph = 1'b0;
    logic pend_valid = 1'b0;
    logic [15:0] pend_b = '0;
    logic prev_rv = 1'b0;
    logic nan_exp = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of stimulus and record what the link must do with it.
    task automatic drive();
        logic [7:0] b;
        pair_t p;
        if (dir_bytes.size() > 0) b = dir_bytes.pop_front();
        else b = 8'($urandom_range(0, 255));
        rx_byte = b;
        if (rx_idx >= RX_SKIP) begin
            if (((rx_idx - RX_SKIP) % 2) == 0) rx_msb = b;
            else begin
                rxq.push_back({rx_msb, b});
                rx_pushed++;
            end
        end
        rx_idx++;

        if (last_acc || !op_valid) begin
            case (mode)
                0: op_valid = 1'b0;
                1: op_valid = ($urandom_range(0, 1) == 1);
                2: op_valid = 1'b1;
                default: op_valid = (dir_pairs.size() > 0);
            endcase
            if (op_valid) begin
                if (dir_pairs.size() > 0) p = dir_pairs.pop_front();
                else begin
                    p.a = 16'($urandom_range(1, 65535));
                    p.b = 16'($urandom_range(0, 65535));
                end
                op_a = p.a;
                op_b = p.b;
            end
        end
        last_acc = op_valid && op_ready;
        if (last_acc) begin
            p.a = op_a;
            p.b = op_b;
            p.acc = cyc + 1;
            txq.push_back(p);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        op_valid = 1'b0;
        last_acc = 1'b0;
        txq.delete();
        rxq.delete();
        rx_idx = 0;
        rx_pushed = 0;
        repeat (3) @(negedge clk);
        chk("rst_tx_data", tx_data, 16'h0000);
        chk("rst_tx_phase", tx_phase, 0);
        chk("rst_op_ready", op_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 16'h0000);
        chk("rst_pair_cnt", pair_cnt, 0);
        chk("rst_res_cnt", res_cnt, 0);
        chk("rst_nan_seen", nan_seen, 0);
        rst_n = 1'b1;
        drive();
    endtask

    // Monitor: consumes expected bus words and results as the DUT presents them.
    always @(negedge clk) begin
        pair_t e;
        logic [15:0] r;
        int lat;
        if (!rst_n) begin
            ph_valid = 1'b0;
            pend_valid = 1'b0;
            pairs_seen = 0;
            res_seen = 0;
            prev_rv = 1'b0;
            nan_exp = 1'b0;
        end else begin
            if (ph_valid) chk("tx_phase_toggle", tx_phase, !last_ph);
            last_ph = tx_phase;
            ph_valid = 1'b1;
            if (!tx_phase) begin
                pend_b = 16'h0000;
                if (tx_data != 16'h0000) begin
                    if (txq.size() == 0) chk("tx_unexpected_pair", tx_data, 16'h0000);
                    else begin
                        e = txq.pop_front();
                        chk("tx_a_slot", tx_data, e.a);
                        lat = cyc - e.acc;
                        chk("tx_latency_1_2", (lat >= 1 && lat <= 2), 1);
                        pend_b = e.b;
                        pairs_seen++;
                        a_log.push_back(cyc);
                    end
                end
                pend_valid = 1'b1;
                chk("pair_cnt", pair_cnt, pairs_seen % (1 << CNT_W));
            end else if (pend_valid) begin
                chk("tx_b_slot", tx_data, pend_b);
            end

            if (res_valid) begin
                chk("res_valid_gap", prev_rv, 0);
                chk("res_expected_avail", (rxq.size() > 0), 1);
                if (rxq.size() > 0) begin
                    r = rxq.pop_front();
                    chk("res_data", res_data, r);
                    if (r == 16'hFFFF) nan_exp = 1'b1;
                end
                res_seen++;
            end
            prev_rv = res_valid;
            chk("res_cnt", res_cnt, res_seen % (1 << CNT_W));
`ifdef DLFLOAT_HOST_LINK_NAN_FLAG_EN
            chk("nan_seen", nan_seen, nan_exp);
`else
            chk("nan_seen_off", nan_seen, 0);
`endif
        end
    end

    initial begin
        int found;

        // Idle link plus the directed rx byte stream.
        mode = 0;
        dir_bytes = '{8'h00, 8'h3E, 8'h00, 8'h40, 8'h12};
        do_reset();
        step(5);
        chk("rx_dir_res_cnt", res_cnt, 2);
        chk("rx_dir_last_word", res_data, 16'h4012);
        step(5);
        chk("idle_pair_cnt", pair_cnt, 0);
        chk("idle_op_ready", op_ready, 1);

        // Single pair offered while tx_phase is 1.
        found = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (tx_phase) begin
                found = 1;
                break;
            end
            drive();
        end
        chk("find_phase1", found, 1);
        mode = 3;
        dir_pairs.push_back('{16'h3E00, 16'h3E00, 0});
        drive();
        step(1);
        chk("single_op_ready_low", op_ready, 0);
        step(3);
        chk("single_pair_cnt", pair_cnt, 1);
        chk("single_op_ready_back", op_ready, 1);

        // Four back-to-back pairs with op_valid held high.
        a_log.delete();
        dir_pairs.push_back('{16'h1111, 16'h2222, 0});
        dir_pairs.push_back('{16'h3333, 16'h4444, 0});
        dir_pairs.push_back('{16'h5555, 16'h6666, 0});
        dir_pairs.push_back('{16'h7777, 16'h8888, 0});
        step(14);
        chk("b2b_pair_cnt", pair_cnt, 5);
        chk("b2b_count", a_log.size(), 4);
        if (a_log.size() == 4)
            for (int i = 0; i < 3; i++) chk("b2b_gap", a_log[i+1] - a_log[i], 2);

        // Randomized traffic, then saturating traffic; counters wrap along the way.
        mode = 1;
        step(700);
        mode = 2;
        step(400);
        mode = 0;
        step(6);
        chk("drain_txq_empty", txq.size(), 0);

        // Reset while the slot is full; then the saturate code on the rx stream.
        mode = 2;
        found = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (!op_ready) begin
                found = 1;
                break;
            end
        end
        chk("find_slot_full", found, 1);
        mode = 0;
        dir_bytes = '{8'h55, 8'hFF, 8'hFF};
        do_reset();
        step(3);
        chk("ff_res_data", res_data, 16'hFFFF);
`ifdef DLFLOAT_HOST_LINK_NAN_FLAG_EN
        chk("ff_nan_set", nan_seen, 1);
`else
        chk("ff_nan_off", nan_seen, 0);
`endif
        chk("post_rst_pair_cnt", pair_cnt, 0);
        mode = 1;
        step(40);
        mode = 0;
        step(6);
        chk("final_txq_empty", txq.size(), 0);
        chk("final_res_delivered", res_seen, rx_pushed - rxq.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
